kbd_rx_ctrl: RTL and testbench
==============================

KBD_RX_CTRL -- requirements
Module: kbd_rx_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 8, receive FIFO entries (power of 2, >= 4).
REQ-002 SHALL have parameter HOLD_FREE, default 1, free-slot count at or below which reception is throttled.
REQ-003 SHALL have parameter RESUME_FREE, default 4, free-slot count at or above which reception resumes (> HOLD_FREE).
REQ-004 SHALL have port i_clk, input, 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have port i_rst, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port i_enable, input, 1, CPU master enable for keyboard reception.
REQ-007 SHALL have port i_ascii, input, 8, character from keyboard datapath.
REQ-008 SHALL have port i_key_received, input, 1, one-cycle strobe qualifying i_ascii.
REQ-009 SHALL have port o_rx_en_ps2, output, 1, reception enable driven to keyboard datapath.
REQ-010 SHALL have port i_rd, input, 1, one-cycle CPU pop strobe.
REQ-011 SHALL have port o_data, output, 8, FIFO head character (show-ahead).
REQ-012 SHALL have port o_rx_ready, output, 1, FIFO non-empty.
REQ-013 SHALL have port o_count, output, $clog2(DEPTH)+1, current occupancy.
REQ-014 SHALL have port o_ovf, output, 1, sticky overflow flag.
REQ-015 SHALL have port i_clr_ovf, input, 1, one-cycle overflow-clear strobe.
REQ-016 SHALL have port i_irq_en, input, 1, interrupt enable.
REQ-017 SHALL have port o_irq, output, 1, level interrupt to CPU.

Function
REQ-018 SHALL implement FSM states OFF, RUN, HOLD; o_rx_en_ps2 = 1 only in RUN, registered.
REQ-019 SHALL transition OFF->RUN when i_enable=1 and free > HOLD_FREE; OFF->HOLD when i_enable=1 and free <= HOLD_FREE.
REQ-020 SHALL transition RUN->HOLD when free (next-cycle value) <= HOLD_FREE; HOLD->RUN when free >= RESUME_FREE.
REQ-021 SHALL transition any state ->OFF when i_enable=0, taking priority over other transitions.
REQ-022 SHALL push i_ascii on i_key_received in every state, since a byte may arrive after disable/throttle.
REQ-023 SHALL pop the head on i_rd when non-empty; i_rd when empty is ignored with no side effect.
REQ-024 SHALL, on simultaneous push and pop while full, perform both; count is unchanged and o_ovf is not set.
REQ-025 SHALL, on simultaneous push and pop while empty, ignore the pop and store the push (count 0->1).
REQ-026 SHALL, on push while full without pop, drop the byte, keep contents, and set o_ovf next cycle.
REQ-027 SHALL hold o_ovf until i_clr_ovf; a simultaneous set and clear leaves o_ovf=1.
REQ-028 SHALL present a pushed byte on o_data with o_rx_ready=1 one cycle after the i_key_received strobe.
REQ-029 SHALL wrap read/write pointers modulo DEPTH, and o_count SHALL reach DEPTH exactly when full.

Reset
REQ-030 SHALL, on i_rst=1 at a clock edge, empty the FIFO, enter OFF, and drive o_rx_en_ps2=0, o_rx_ready=0, o_count=0, o_ovf=0, o_irq=0; o_data is don't-care.
REQ-031 SHALL give i_rst priority over all strobes arriving in the same cycle; FIFO contents are discarded mid-operation.

Configuration
REQ-032 SHALL, with KBD_RX_IRQ_EN defined, drive o_irq registered = i_irq_en & (o_rx_ready | o_ovf).
REQ-033 SHALL, with KBD_RX_IRQ_EN undefined, tie o_irq to 0 and ignore i_irq_en; all other behaviour is identical.

Structure
REQ-034 SHALL place FSM state encoding (OFF/RUN/HOLD) and default DEPTH/threshold constants in shared package kbd_pkg.
REQ-035 SHALL implement storage as sub-module kbd_rx_fifo (sync FIFO, show-ahead, count output); FSM, overflow, and irq logic stay in kbd_rx_ctrl.

Verification
REQ-036 SHALL test: reset, i_enable=1, push 0x41 -> next cycle o_data=0x41, o_rx_ready=1, o_count=1; i_rd -> o_count=0.
REQ-037 SHALL test: DEPTH=8, push 7 bytes without reads -> o_rx_en_ps2 falls after the 7th push (free=1); pop 3 -> o_rx_en_ps2 returns to 1 (free=4).
REQ-038 SHALL test: fill 8, push 0x5A -> dropped, o_ovf=1, o_count=8; i_clr_ovf -> o_ovf=0.
REQ-039 SHALL test: full FIFO, same-cycle push 0x30 and i_rd -> o_count stays 8, o_ovf=0, 0x30 read last; empty FIFO, same-cycle push and i_rd -> o_count=1.
REQ-040 SHALL test: i_enable=0 with a push strobe in flight -> byte stored, o_rx_en_ps2=0; i_rst with 3 entries -> o_count=0, state OFF.
REQ-041 SHALL test: KBD_RX_IRQ_EN defined, i_irq_en=1, push one byte -> o_irq=1 until popped; undefined -> o_irq stays 0.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared types and default sizing for the keyboard receive controller.
package kbd_pkg;

   typedef enum logic [1:0] {
      StOff  = 2'd0,
      StRun  = 2'd1,
      StHold = 2'd2
   } kbd_state_e;

   localparam int unsigned KBD_DEPTH       = 8;
   localparam int unsigned KBD_HOLD_FREE   = 1;
   localparam int unsigned KBD_RESUME_FREE = 4;

endpackage

// File: rtl/kbd_rx_ctrl_if.sv
// CPU-side register/strobe bundle of the keyboard receive controller.
interface kbd_rx_ctrl_if
   import kbd_pkg::*;
#(
   parameter int unsigned DEPTH = KBD_DEPTH
);
   logic                     i_enable;
   logic                     i_irq_en;
   logic                     o_irq;
   logic                     i_rd;
   logic [7:0]               o_data;
   logic                     o_rx_ready;
   logic [$clog2(DEPTH):0]   o_count;
   logic                     o_ovf;
   logic                     i_clr_ovf;

   modport slave (
      input  i_enable, i_irq_en, i_rd, i_clr_ovf,
      output o_irq, o_data, o_rx_ready, o_count, o_ovf
   );

   modport master (
      output i_enable, i_irq_en, i_rd, i_clr_ovf,
      input  o_irq, o_data, o_rx_ready, o_count, o_ovf
   );
endinterface

// File: rtl/kbd_rx_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and drop indication.
module kbd_rx_fifo #(
   parameter int unsigned DEPTH = 8,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned CW = AW + 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_push,
   input  logic [7:0]    i_data,
   input  logic          i_pop,
   output logic [7:0]    o_data,
   output logic [CW-1:0] o_count,
   output logic [CW-1:0] o_count_nxt,
   output logic          o_empty,
   output logic          o_full,
   output logic          o_drop
);
   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CW'(DEPTH));
   // A pop of an empty FIFO is ignored; a push into a full FIFO needs a real pop.
   assign w_pop   = i_pop & ~o_empty;
   assign w_push  = i_push & (~o_full | w_pop);
   assign o_drop  = i_push & ~w_push;
   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   always_comb begin
      o_count_nxt = r_count;
      if (w_push && !w_pop) begin
         o_count_nxt = r_count + CW'(1);
      end else if (!w_push && w_pop) begin
         o_count_nxt = r_count - CW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= o_count_nxt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push && !i_rst) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end
endmodule

// File: rtl/kbd_rx_ctrl.sv
// Keyboard receive controller: FIFO buffering, flow-control FSM, overflow and irq.
// Define KBD_RX_IRQ_EN to enable the interrupt output.
module kbd_rx_ctrl
   import kbd_pkg::*;
#(
   parameter int unsigned DEPTH       = KBD_DEPTH,
   parameter int unsigned HOLD_FREE   = KBD_HOLD_FREE,
   parameter int unsigned RESUME_FREE = KBD_RESUME_FREE
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [7:0]    i_ascii,
   input  logic          i_key_received,
   output logic          o_rx_en_ps2,
   kbd_rx_ctrl_if.slave  cpu
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   kbd_state_e    r_state;
   kbd_state_e    w_state_d;
   logic          r_rx_en;
   logic          r_ovf;
   logic          w_ovf_d;
   logic [7:0]    w_data;
   logic [CW-1:0] w_count;
   logic [CW-1:0] w_count_nxt;
   logic          w_empty;
   logic          w_full;
   logic          w_drop;
   logic [31:0]   w_free;
   logic          w_throttle;
   logic          w_resume;

   kbd_rx_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_push      (i_key_received),
      .i_data      (i_ascii),
      .i_pop       (cpu.i_rd),
      .o_data      (w_data),
      .o_count     (w_count),
      .o_count_nxt (w_count_nxt),
      .o_empty     (w_empty),
      .o_full      (w_full),
      .o_drop      (w_drop)
   );

   // Thresholds look at next-cycle occupancy so throttling reacts to the push in flight.
   assign w_free     = DEPTH - 32'(w_count_nxt);
   assign w_throttle = (w_free <= HOLD_FREE);
   assign w_resume   = (w_free >= RESUME_FREE);

   always_comb begin
      w_state_d = r_state;
      if (!cpu.i_enable) begin
         w_state_d = StOff;
      end else begin
         unique case (r_state)
            StOff:   w_state_d = w_throttle ? StHold : StRun;
            StRun:   if (w_throttle) w_state_d = StHold;
            StHold:  if (w_resume) w_state_d = StRun;
            default: w_state_d = StOff;
         endcase
      end
   end

   always_comb begin
      w_ovf_d = r_ovf;
      if (w_drop) begin
         w_ovf_d = 1'b1;
      end else if (cpu.i_clr_ovf) begin
         w_ovf_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StOff;
         r_rx_en <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_rx_en <= (w_state_d == StRun);
         r_ovf   <= w_ovf_d;
      end
   end

`ifdef KBD_RX_IRQ_EN
   logic r_irq;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= cpu.i_irq_en & (~w_empty | r_ovf);
      end
   end

   assign cpu.o_irq = r_irq;
`else
   logic w_unused_irq_en;

   assign w_unused_irq_en = cpu.i_irq_en;
   assign cpu.o_irq       = 1'b0;
`endif

   logic w_unused_full;
   assign w_unused_full = w_full;

   assign o_rx_en_ps2    = r_rx_en;
   assign cpu.o_data     = w_data;
   assign cpu.o_rx_ready = ~w_empty;
   assign cpu.o_count    = w_count;
   assign cpu.o_ovf      = r_ovf;
endmodule

// File: tb/tb_kbd_rx_ctrl.sv
// Directed self-checking bench for kbd_rx_ctrl (DEPTH=8, HOLD_FREE=1, RESUME_FREE=4).
module tb_kbd_rx_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] ascii;
   logic       key_rx;
   logic       rx_en_ps2;
   int         n_checks = 0;
   int         n_errors = 0;
   logic [7:0] exp_order [8];
   logic       irq_exp;

   kbd_rx_ctrl_if #(.DEPTH(8)) cpu_if ();

   kbd_rx_ctrl #(
      .DEPTH       (8),
      .HOLD_FREE   (1),
      .RESUME_FREE (4)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_ascii        (ascii),
      .i_key_received (key_rx),
      .o_rx_en_ps2    (rx_en_ps2),
      .cpu            (cpu_if)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      ascii  = b;
      key_rx = 1'b1;
      tick();
      key_rx = 1'b0;
   endtask

   task automatic pop();
      cpu_if.i_rd = 1'b1;
      tick();
      cpu_if.i_rd = 1'b0;
   endtask

   initial begin
`ifdef KBD_RX_IRQ_EN
      irq_exp = 1'b1;
`else
      irq_exp = 1'b0;
`endif
      exp_order = '{8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h30};
      rst              = 1'b1;
      ascii            = 8'h00;
      key_rx           = 1'b0;
      cpu_if.i_enable  = 1'b0;
      cpu_if.i_irq_en  = 1'b1;
      cpu_if.i_rd      = 1'b0;
      cpu_if.i_clr_ovf = 1'b0;
      #1;
      tick();
      tick();
      rst = 1'b0;
      check("rst_rx_en", 32'(rx_en_ps2), 32'd0);
      check("rst_ready", 32'(cpu_if.o_rx_ready), 32'd0);
      check("rst_count", 32'(cpu_if.o_count), 32'd0);
      check("rst_ovf", 32'(cpu_if.o_ovf), 32'd0);
      check("rst_irq", 32'(cpu_if.o_irq), 32'd0);

      pop();
      check("empty_pop_count", 32'(cpu_if.o_count), 32'd0);

      cpu_if.i_enable = 1'b1;
      tick();
      check("enable_rx_en", 32'(rx_en_ps2), 32'd1);

      // Single byte round trip
      push(8'h41);
      check("push_data", 32'(cpu_if.o_data), 32'h41);
      check("push_ready", 32'(cpu_if.o_rx_ready), 32'd1);
      check("push_count", 32'(cpu_if.o_count), 32'd1);
      tick();
      check("irq_set", 32'(cpu_if.o_irq), 32'(irq_exp));
      pop();
      check("pop_count", 32'(cpu_if.o_count), 32'd0);
      check("pop_ready", 32'(cpu_if.o_rx_ready), 32'd0);
      tick();
      check("irq_clear", 32'(cpu_if.o_irq), 32'd0);

      // Throttle after 7th push, resume when free reaches 4
      for (int i = 1; i <= 6; i++) push(8'(i));
      check("six_rx_en", 32'(rx_en_ps2), 32'd1);
      push(8'h07);
      check("seven_rx_en", 32'(rx_en_ps2), 32'd0);
      check("seven_count", 32'(cpu_if.o_count), 32'd7);
      pop();
      pop();
      check("pop2_rx_en", 32'(rx_en_ps2), 32'd0);
      pop();
      check("pop3_rx_en", 32'(rx_en_ps2), 32'd1);
      check("pop3_head", 32'(cpu_if.o_data), 32'h04);

      // Fill to 8 then overflow
      for (int i = 8; i <= 11; i++) push(8'(i));
      check("full_count", 32'(cpu_if.o_count), 32'd8);
      push(8'h5A);
      check("ovf_set", 32'(cpu_if.o_ovf), 32'd1);
      check("ovf_count", 32'(cpu_if.o_count), 32'd8);
      check("ovf_head", 32'(cpu_if.o_data), 32'h04);
      cpu_if.i_clr_ovf = 1'b1;
      push(8'h5B);
      cpu_if.i_clr_ovf = 1'b0;
      check("ovf_set_clr", 32'(cpu_if.o_ovf), 32'd1);
      cpu_if.i_clr_ovf = 1'b1;
      tick();
      cpu_if.i_clr_ovf = 1'b0;
      check("ovf_clr", 32'(cpu_if.o_ovf), 32'd0);

      // Full: simultaneous push and pop
      cpu_if.i_rd = 1'b1;
      push(8'h30);
      cpu_if.i_rd = 1'b0;
      check("fullpp_count", 32'(cpu_if.o_count), 32'd8);
      check("fullpp_ovf", 32'(cpu_if.o_ovf), 32'd0);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("drain_%0d", i), 32'(cpu_if.o_data), 32'(exp_order[i]));
         pop();
      end
      check("drain_count", 32'(cpu_if.o_count), 32'd0);

      // Empty: simultaneous push and pop
      cpu_if.i_rd = 1'b1;
      push(8'h77);
      cpu_if.i_rd = 1'b0;
      check("emptypp_count", 32'(cpu_if.o_count), 32'd1);
      check("emptypp_data", 32'(cpu_if.o_data), 32'h77);
      pop();

      // Disable with a strobe in flight, then reset with 3 entries
      cpu_if.i_enable = 1'b0;
      push(8'h55);
      check("dis_count", 32'(cpu_if.o_count), 32'd1);
      check("dis_data", 32'(cpu_if.o_data), 32'h55);
      check("dis_rx_en", 32'(rx_en_ps2), 32'd0);
      push(8'h56);
      push(8'h57);
      check("dis_count3", 32'(cpu_if.o_count), 32'd3);
      cpu_if.i_enable = 1'b1;
      rst = 1'b1;
      cpu_if.i_rd = 1'b1;
      push(8'h58);
      cpu_if.i_rd = 1'b0;
      rst = 1'b0;
      check("rst_mid_count", 32'(cpu_if.o_count), 32'd0);
      check("rst_mid_ready", 32'(cpu_if.o_rx_ready), 32'd0);
      check("rst_mid_rx_en", 32'(rx_en_ps2), 32'd0);
      tick();
      check("rst_mid_resume", 32'(rx_en_ps2), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
